// File: rtl/prmcu_uart_pkg.sv
// Shared types and constants for the UART TX requester arbiter.
// Holds the FSM state encoding and the beat counter helpers.
package prmcu_uart_pkg;

    localparam int DAT_W_DEF = 9;
    localparam int CNT_W     = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/prmcu_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_ptr.
// Produces both a one-hot grant and its binary index.
module prmcu_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    int               k;
    logic [IDX_W-1:0] ki;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        k       = 0;
        ki      = '0;
        // Scan starts just past the previous owner, wrapping once.
        for (int i = 1; i <= N_REQ; i++) begin
            k  = (int'(last_ptr) + i) % N_REQ;
            ki = IDX_W'(k);
            if (!any && req[ki]) begin
                any     = 1'b1;
                gnt[ki] = 1'b1;
                gnt_idx = ki;
            end
        end
    end

endmodule

// File: rtl/prmcu_uart_tx_arbiter.sv
// Multiplexes N_REQ burst requesters onto one UART TX beat stream.
// IDLE/BURST FSM, burst counter and data mux; pick is in prmcu_rr_arbiter.
module prmcu_uart_tx_arbiter
    import prmcu_uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DAT_W = DAT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [7:0]             max_burst_i,
    input  logic [N_REQ*DAT_W-1:0] req_dat_i,
    input  logic [N_REQ-1:0]       req_vld_i,
    input  logic [N_REQ-1:0]       req_last_i,
    output logic [N_REQ-1:0]       req_rdy_o,
    output logic [DAT_W-1:0]       out_dat_o,
    output logic                   out_vld_o,
    input  logic                   out_rdy_i,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] max_q, max_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic [DAT_W-1:0] own_dat;
    logic             own_vld;
    logic             own_last;
    logic             live;
    logic             beat_acc;
    logic             cnt_hit;
    logic             burst_end;

    prmcu_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req      (req_vld_i),
        .last_ptr (last_ptr_q),
        .gnt      (pick_gnt),
        .gnt_idx  (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        own_dat  = '0;
        own_vld  = 1'b0;
        own_last = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                own_dat  = req_dat_i[k*DAT_W +: DAT_W];
                own_vld  = req_vld_i[k];
                own_last = req_last_i[k];
            end
        end
    end

    // Outputs are forced low while rst is held, even before the edge.
    assign live      = (state_q == ST_BURST) && !rst;
    assign beat_acc  = live && own_vld && out_rdy_i;
    assign cnt_hit   = (max_q != '0) && (sat_inc(cnt_q) == max_q);
    assign burst_end = beat_acc && (own_last || cnt_hit);

    assign busy_o    = live;
    assign grant_o   = live ? grant_q : '0;
    assign out_vld_o = live && own_vld;
    assign out_dat_o = live ? own_dat : '0;
    assign req_rdy_o = (live && out_rdy_i) ? grant_q : '0;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        last_ptr_d = last_ptr_q;
        cnt_d      = cnt_q;
        max_d      = max_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en && pick_any) begin
                    state_d = ST_BURST;
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    max_d   = max_burst_i;
                end
            end
            ST_BURST: begin
                if (beat_acc) begin
                    cnt_d = sat_inc(cnt_q);
                end
                if (burst_end) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    last_ptr_d = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_ptr_q <= PTR_RST;
            cnt_q      <= '0;
            max_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            last_ptr_q <= last_ptr_d;
            cnt_q      <= cnt_d;
            max_q      <= max_d;
        end
    end

endmodule
